// File: rtl/mem_step_sequencer.sv
// mem_step_sequencer
// Timed scan controller for the memory-to-VGA path. A free-running prescaler
// produces a one-cycle tick every TICK_DIV clocks while a scan is active. Each
// tick launches one req/ack read of the frame memory, stepping through
// addresses 0..DEPTH-1. Each returned word is registered onto oData with a
// one-cycle oDataValid pulse. Scans are one-shot or looping and can be
// aborted with iStop. oOverrun records a tick that arrives while a read is
// still outstanding; that tick is dropped.
module mem_step_sequencer #(
    parameter int TICK_DIV = 25000000,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iStop,
    input  logic              iLoop,
    output logic              oMemReq,
    output logic [ADDR_W-1:0] oMemAddr,
    input  logic              iMemAck,
    input  logic [DATA_W-1:0] iMemData,
    output logic [DATA_W-1:0] oData,
    output logic              oDataValid,
    output logic              oDone,
    output logic              oBusy,
    output logic              oOverrun
);

    localparam int                PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        REQ
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [PRE_W-1:0]  presc;
    logic [PRE_W-1:0]  prescNext;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addrNext;
    logic              tick;
    logic              dataLoad;
    logic              doneNext;
    logic              overrunSet;
    logic              overrunClr;

    // Prescaler advance with an explicit wrap at TICK_DIV-1, so non-power-of-two
    // periods never rely on counter overflow.
    function automatic logic [PRE_W-1:0] prescStep(input logic [PRE_W-1:0] cur);
        return (cur == PRE_LAST) ? '0 : cur + 1'b1;
    endfunction

    // Address advance with an explicit wrap at DEPTH-1. DEPTH need not fill
    // the address space.
    function automatic logic [ADDR_W-1:0] addrStep(input logic [ADDR_W-1:0] cur);
        return (cur == ADDR_LAST) ? '0 : cur + 1'b1;
    endfunction

    // The tick exists only while a scan is active. The prescaler is pinned to 0 in IDLE.
    assign tick = (state != IDLE) && (presc == PRE_LAST);

    // Request and address are decoded straight from registered state, so they
    // stay stable for the whole time a read is outstanding.
    assign oMemReq  = (state == REQ);
    assign oMemAddr = addr;
    assign oBusy    = (state != IDLE);

    // Next-state, prescaler, address and output-event decode
    always_comb begin
        stateNext  = state;
        prescNext  = presc;
        addrNext   = addr;
        dataLoad   = 1'b0;
        doneNext   = 1'b0;
        overrunSet = 1'b0;
        overrunClr = 1'b0;

        case (state)
            IDLE: begin
                prescNext = '0;
                // A simultaneous stop vetoes the start.
                if (iStart && !iStop) begin
                    stateNext  = WAIT_TICK;
                    addrNext   = '0;
                    overrunClr = 1'b1;
                end
            end

            WAIT_TICK: begin
                prescNext = prescStep(presc);
                if (iStop) begin
                    stateNext = IDLE;
                    prescNext = '0;
                    addrNext  = '0;
                end else if (tick) begin
                    stateNext = REQ;
                end
            end

            REQ: begin
                // The prescaler keeps running during a read so the tick rate
                // never stretches with memory latency.
                prescNext = prescStep(presc);
                if (iStop) begin
                    // Abort wins over a same-cycle ack. The word is discarded.
                    stateNext = IDLE;
                    prescNext = '0;
                    addrNext  = '0;
                end else begin
                    // A tick that arrives with the read still pending is
                    // flagged and dropped. The next read waits for the following tick.
                    if (tick) begin
                        overrunSet = 1'b1;
                    end
                    if (iMemAck) begin
                        dataLoad = 1'b1;
                        if (addr == ADDR_LAST) begin
                            addrNext = addrStep(addr);
                            if (iLoop) begin
                                stateNext = WAIT_TICK;
                            end else begin
                                stateNext = IDLE;
                                prescNext = '0;
                                doneNext  = 1'b1;
                            end
                        end else begin
                            addrNext  = addrStep(addr);
                            stateNext = WAIT_TICK;
                        end
                    end
                end
            end

            default: begin
                stateNext = IDLE;
                prescNext = '0;
                addrNext  = '0;
            end
        endcase
    end

    // Control registers: FSM state, prescaler and scan address
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            presc <= '0;
            addr  <= '0;
        end else begin
            state <= stateNext;
            presc <= prescNext;
            addr  <= addrNext;
        end
    end

    // Display register stage: captured word, valid/done pulses, sticky overrun
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oData      <= '0;
            oDataValid <= 1'b0;
            oDone      <= 1'b0;
            oOverrun   <= 1'b0;
        end else begin
            if (dataLoad) begin
                oData <= iMemData;
            end
            oDataValid <= dataLoad;
            oDone      <= doneNext;
            if (overrunClr) begin
                oOverrun <= 1'b0;
            end else if (overrunSet) begin
                oOverrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_step_sequencer.sv
// tb_mem_step_sequencer
// Scoreboard bench for mem_step_sequencer. It uses a small TB memory and a
// transaction-level reference model. The model advances once per clock edge
// and predicts two things: which address is requested at which edge, and
// which word, with or without oDone, is presented at which edge. A separate
// monitor on the falling edge pops and compares those predictions.
module tb_mem_step_sequencer;

    localparam int TICK_DIV = 5;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 8;

    logic              iClk     = 1'b0;
    logic              iRst     = 1'b0;
    logic              iStart   = 1'b0;
    logic              iStop    = 1'b0;
    logic              iLoop    = 1'b0;
    logic              iMemAck  = 1'b0;
    logic [DATA_W-1:0] iMemData = '0;
    logic              oMemReq;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oData;
    logic              oDataValid;
    logic              oDone;
    logic              oBusy;
    logic              oOverrun;

    int nChecks = 0;
    int nErrors = 0;

    always #5 iClk = ~iClk;

    mem_step_sequencer #(
        .TICK_DIV(TICK_DIV),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iStop     (iStop),
        .iLoop     (iLoop),
        .oMemReq   (oMemReq),
        .oMemAddr  (oMemAddr),
        .iMemAck   (iMemAck),
        .iMemData  (iMemData),
        .oData     (oData),
        .oDataValid(oDataValid),
        .oDone     (oDone),
        .oBusy     (oBusy),
        .oOverrun  (oOverrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- TB memory ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    int memLat  = 0;
    bit spurious = 1'b0;
    int waitCnt = 0;

    initial begin : memResponder
        forever begin
            @(negedge iClk);
            if (oMemReq === 1'b1) begin
                if (waitCnt >= memLat) begin
                    iMemAck  = 1'b1;
                    iMemData = mem[oMemAddr];
                    waitCnt  = 0;
                end else begin
                    iMemAck = 1'b0;
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
                if (spurious && ($urandom_range(0, 3) == 0)) begin
                    iMemAck  = 1'b1;
                    iMemData = 8'($urandom);
                end else begin
                    iMemAck = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [DATA_W-1:0] data;
        bit                done;
        int                at;
    } dexp_t;
    typedef struct {
        int addr;
        int at;
    } aexp_t;

    dexp_t dataQ[$];
    aexp_t addrQ[$];

    bit mBusy      = 1'b0;
    bit mPending   = 1'b0;
    bit mOverrun   = 1'b0;
    bit mTick      = 1'b0;
    bit mDone      = 1'b0;
    int mAddr      = 0;
    int mStartEdge = 0;
    int ecount     = 0;

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mBusy    = 1'b0;
            mPending = 1'b0;
            mOverrun = 1'b0;
            mAddr    = 0;
            dataQ.delete();
            addrQ.delete();
        end else begin
            ecount++;
            // Ticks fall on every TICK_DIV-th edge after the accepted start.
            mTick = mBusy && (((ecount - mStartEdge) % TICK_DIV) == 0);
            if (!mBusy) begin
                if (iStart && !iStop) begin
                    mBusy      = 1'b1;
                    mPending   = 1'b0;
                    mAddr      = 0;
                    mOverrun   = 1'b0;
                    mStartEdge = ecount;
                end
            end else if (iStop) begin
                mBusy    = 1'b0;
                mPending = 1'b0;
                mAddr    = 0;
            end else if (mPending) begin
                if (mTick) mOverrun = 1'b1;
                if (iMemAck) begin
                    mDone = (mAddr == DEPTH - 1) && !iLoop;
                    dataQ.push_back('{data: mem[mAddr], done: mDone, at: ecount});
                    mPending = 1'b0;
                    mAddr    = (mAddr + 1) % DEPTH;
                    if (mDone) mBusy = 1'b0;
                end
            end else if (mTick) begin
                mPending = 1'b1;
                addrQ.push_back('{addr: mAddr, at: ecount});
            end
        end
    end

    // ---------------- monitor ----------------
    bit                prevReq = 1'b0;
    logic [ADDR_W-1:0] heldAddr = '0;
    dexp_t             dGot;
    aexp_t             aGot;

    always @(negedge iClk) begin
        if (iRst) begin
            prevReq = 1'b0;
        end else begin
            check("busy", 32'(oBusy), 32'(mBusy));
            check("overrun", 32'(oOverrun), 32'(mOverrun));
            check("memReq", 32'(oMemReq), 32'(mPending));
            if (oMemReq && !prevReq) begin
                check("reqExpected", 32'(addrQ.size() != 0), 32'd1);
                if (addrQ.size() != 0) begin
                    aGot = addrQ.pop_front();
                    check("reqAddr", 32'(oMemAddr), 32'(aGot.addr));
                    check("reqEdge", 32'(ecount), 32'(aGot.at));
                end
                heldAddr = oMemAddr;
            end else if (oMemReq) begin
                check("addrStable", 32'(oMemAddr), 32'(heldAddr));
            end
            prevReq = oMemReq;
            if (oDataValid) begin
                check("validExpected", 32'(dataQ.size() != 0), 32'd1);
                if (dataQ.size() != 0) begin
                    dGot = dataQ.pop_front();
                    check("data", 32'(oData), 32'(dGot.data));
                    check("done", 32'(oDone), 32'(dGot.done));
                    check("dataEdge", 32'(ecount), 32'(dGot.at));
                end
            end else begin
                check("doneWithoutValid", 32'(oDone), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge iClk);
            #2;
        end
    endtask

    task automatic pulseStart();
        iStart = 1'b1;
        cyc(1);
        iStart = 1'b0;
    endtask

    task automatic waitIdle(input int maxC, input string name);
        int c;
        c = 0;
        while (mBusy && (c < maxC)) begin
            cyc(1);
            c++;
        end
        check(name, 32'(oBusy), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_req"}, 32'(oMemReq), 32'd0);
        check({tag, "_addr"}, 32'(oMemAddr), 32'd0);
        check({tag, "_data"}, 32'(oData), 32'd0);
        check({tag, "_valid"}, 32'(oDataValid), 32'd0);
        check({tag, "_done"}, 32'(oDone), 32'd0);
        check({tag, "_busy"}, 32'(oBusy), 32'd0);
        check({tag, "_overrun"}, 32'(oOverrun), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hA0 + i);

        // Reset asserted between clock edges
        #3 iRst = 1'b1;
        #1 checkAllZero("reset");
        cyc(2);
        iRst = 1'b0;
        cyc(2);

        // One-shot pass, ack in the request cycle
        iLoop  = 1'b0;
        memLat = 0;
        pulseStart();
        waitIdle(60, "oneshotIdle");
        check("oneshotLast", 32'(oData), 32'h0000_00A3);
        cyc(3);

        // Looping scan, then drop iLoop to finish the current pass
        iLoop = 1'b1;
        pulseStart();
        cyc(45);
        iLoop = 1'b0;
        waitIdle(60, "loopIdle");

        // Slow memory: overrun sticky, cleared by the next start
        memLat = 7;
        pulseStart();
        waitIdle(120, "slowIdle");
        check("overrunSticky", 32'(oOverrun), 32'd1);
        cyc(5);
        check("overrunStillSet", 32'(oOverrun), 32'd1);
        memLat = 0;
        pulseStart();
        cyc(2);
        check("overrunCleared", 32'(oOverrun), 32'd0);
        waitIdle(60, "afterOverrunIdle");

        // Stop in the same cycle as the ack
        pulseStart();
        c = 0;
        while (!mPending && (c < 20)) begin
            cyc(1);
            c++;
        end
        check("stopReqSeen", 32'(oMemReq), 32'd1);
        iStop = 1'b1;
        cyc(1);
        iStop = 1'b0;
        check("stopBusy", 32'(oBusy), 32'd0);
        check("stopReq", 32'(oMemReq), 32'd0);
        check("stopNoValid", 32'(oDataValid), 32'd0);
        check("stopNoDone", 32'(oDone), 32'd0);
        pulseStart();
        waitIdle(60, "restartIdle");

        // Start and stop together in IDLE; start while busy
        iStart = 1'b1;
        iStop  = 1'b1;
        cyc(1);
        iStart = 1'b0;
        iStop  = 1'b0;
        cyc(1);
        check("startStopIdle", 32'(oBusy), 32'd0);
        pulseStart();
        cyc(7);
        pulseStart();
        waitIdle(60, "busyStartIdle");

        // Acks outside REQ must be ignored
        spurious = 1'b1;
        pulseStart();
        waitIdle(60, "spuriousIdle");
        spurious = 1'b0;

        // Asynchronous reset mid-scan
        iLoop = 1'b1;
        pulseStart();
        cyc(13);
        #1 iRst = 1'b1;
        #1 checkAllZero("midReset");
        cyc(2);
        iRst  = 1'b0;
        iLoop = 1'b0;
        cyc(2);

        // Randomized phase with random memory contents
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        for (int it = 0; it < 1500; it++) begin
            iLoop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) memLat = int'($urandom_range(0, 8));
            spurious = 1'($urandom_range(0, 1));
            iStart   = ($urandom_range(0, 15) == 0);
            iStop    = ($urandom_range(0, 60) == 0);
            cyc(1);
        end
        iStart   = 1'b0;
        iStop    = 1'b1;
        spurious = 1'b0;
        cyc(1);
        iStop = 1'b0;
        cyc(3);
        check("queuesDrained", 32'(dataQ.size() + addrQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
